// File: rtl/pll_reset_seq.sv
`default_nettype none
// ============================================================================
// Module      : pll_reset_seq
// Description : PLL reset sequencer. Pulses the PLL reset, waits for lock
//               with a timeout and bounded retries, qualifies the lock as
//               stable, then releases the downstream system reset.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   refclk      in   sole clock, all logic on its rising edge
//   rst_n       in   synchronous active-low reset
//   soft_rst    in   one-cycle request to restart the sequence from HOLD
//   pll_locked  in   PLL lock flag, asynchronous to refclk
//   pll_rst     out  active-high reset to the PLL
//   sys_reset   out  active-high reset to downstream logic
//   ready       out  high only in RUN
//   fail        out  high only in FAIL
//   retry_cnt   out  PLL reset attempts consumed, saturating at 3
//   state       out  HOLD=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4
// Configuration
//   PLL_SEQ_LOCK_MONITOR_EN  when defined, two consecutive unlocked cycles
//                            in RUN send the sequencer back to HOLD without
//                            consuming an attempt. When undefined, RUN is
//                            left only through rst_n or soft_rst.
// ============================================================================
module pll_reset_seq #(
    parameter int RST_HOLD_CYCLES     = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int MAX_RETRIES         = 3
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       soft_rst,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       sys_reset,
    output logic       ready,
    output logic       fail,
    output logic [1:0] retry_cnt,
    output logic [2:0] state
);

    // One counter serves every timed state, so it is sized for the longest.
    localparam int c_CNT_MAX_AB = (RST_HOLD_CYCLES > LOCK_STABLE_CYCLES) ?
                                  RST_HOLD_CYCLES : LOCK_STABLE_CYCLES;
    localparam int c_CNT_MAX    = (c_CNT_MAX_AB > LOCK_TIMEOUT_CYCLES) ?
                                  c_CNT_MAX_AB : LOCK_TIMEOUT_CYCLES;
    localparam int c_CW         = $clog2(c_CNT_MAX + 1);
    // Attempt counter holds 0..MAX_RETRIES; +2 keeps it at least one bit wide.
    localparam int c_RW         = $clog2(MAX_RETRIES + 2);

    localparam logic [c_CW-1:0] c_HOLD_LAST = c_CW'(RST_HOLD_CYCLES - 1);
    localparam logic [c_CW-1:0] c_STB_LAST  = c_CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [c_CW-1:0] c_TMO_LAST  = c_CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [c_CW-1:0] c_CNT_ONE   = c_CW'(1);
    localparam logic [c_RW-1:0] c_RETRY_ONE = c_RW'(1);
    localparam logic [c_RW-1:0] c_RETRY_MAX = c_RW'(MAX_RETRIES);

    localparam logic [2:0] c_ST_HOLD   = 3'd0;
    localparam logic [2:0] c_ST_WAIT   = 3'd1;
    localparam logic [2:0] c_ST_STABLE = 3'd2;
    localparam logic [2:0] c_ST_RUN    = 3'd3;
    localparam logic [2:0] c_ST_FAIL   = 3'd4;

    logic [2:0]      r_state;
    logic [c_CW-1:0] r_cnt;
    logic [c_RW-1:0] r_retry;
    logic [1:0]      r_retry_sat;
    logic            r_lk_meta;
    logic            r_lk;
    logic            r_pll_rst;
    logic            r_sys_reset;
    logic            r_ready;
    logic            r_fail;

    logic [2:0]      w_state_nxt;
    logic [c_CW-1:0] w_cnt_nxt;
    logic [c_RW-1:0] w_retry_nxt;
    logic [1:0]      w_retry_sat_nxt;

    // Two-flop synchronizer; only r_lk is used by the sequencer.
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            r_lk_meta <= 1'b0;
            r_lk      <= 1'b0;
        end else begin
            r_lk_meta <= pll_locked;
            r_lk      <= r_lk_meta;
        end
    end

`ifdef PLL_SEQ_LOCK_MONITOR_EN
    // Remembers that lock was absent on the previous cycle, so RUN can
    // ignore a single-cycle dropout.
    logic r_lk_low;

    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            r_lk_low <= 1'b0;
        end else begin
            r_lk_low <= ~r_lk;
        end
    end
`endif

    // Next-state logic. The counter is cleared on every transition and
    // only counts while below the terminal value of the current state.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_retry_nxt     = r_retry;
        w_retry_sat_nxt = r_retry_sat;

        if (soft_rst) begin
            w_state_nxt     = c_ST_HOLD;
            w_cnt_nxt       = '0;
            w_retry_nxt     = '0;
            w_retry_sat_nxt = 2'd0;
        end else begin
            case (r_state)
                c_ST_HOLD: begin
                    if (r_cnt == c_HOLD_LAST) begin
                        w_state_nxt = c_ST_WAIT;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + c_CNT_ONE;
                    end
                end
                c_ST_WAIT: begin
                    if (r_lk) begin
                        w_state_nxt = c_ST_STABLE;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == c_TMO_LAST) begin
                        w_cnt_nxt = '0;
                        if (r_retry < c_RETRY_MAX) begin
                            w_state_nxt     = c_ST_HOLD;
                            w_retry_nxt     = r_retry + c_RETRY_ONE;
                            w_retry_sat_nxt = (r_retry_sat == 2'd3) ?
                                              2'd3 : r_retry_sat + 2'd1;
                        end else begin
                            w_state_nxt = c_ST_FAIL;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + c_CNT_ONE;
                    end
                end
                c_ST_STABLE: begin
                    // Losing lock here restarts the wait without costing
                    // an attempt.
                    if (!r_lk) begin
                        w_state_nxt = c_ST_WAIT;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == c_STB_LAST) begin
                        w_state_nxt = c_ST_RUN;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + c_CNT_ONE;
                    end
                end
                c_ST_RUN: begin
`ifdef PLL_SEQ_LOCK_MONITOR_EN
                    if (!r_lk && r_lk_low) begin
                        w_state_nxt = c_ST_HOLD;
                        w_cnt_nxt   = '0;
                    end
`endif
                end
                c_ST_FAIL: begin
                    w_state_nxt = c_ST_FAIL;
                end
                default: begin
                    w_state_nxt = c_ST_HOLD;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // State register. Outputs are decoded from the next state so they are
    // registered yet change on the same edge as the state itself.
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            r_state     <= c_ST_HOLD;
            r_cnt       <= '0;
            r_retry     <= '0;
            r_retry_sat <= 2'd0;
            r_pll_rst   <= 1'b1;
            r_sys_reset <= 1'b1;
            r_ready     <= 1'b0;
            r_fail      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_retry     <= w_retry_nxt;
            r_retry_sat <= w_retry_sat_nxt;
            r_pll_rst   <= (w_state_nxt == c_ST_HOLD) || (w_state_nxt == c_ST_FAIL);
            // RUN is reachable only from STABLE, so this is the sole release.
            r_sys_reset <= (w_state_nxt != c_ST_RUN);
            r_ready     <= (w_state_nxt == c_ST_RUN);
            r_fail      <= (w_state_nxt == c_ST_FAIL);
        end
    end

    assign pll_rst   = r_pll_rst;
    assign sys_reset = r_sys_reset;
    assign ready     = r_ready;
    assign fail      = r_fail;
    assign retry_cnt = r_retry_sat;
    assign state     = r_state;

endmodule
`default_nettype wire
